// File: rtl/calib_pkg.sv
// Shared widths and FSM encoding for the calibration tracker slice.
package calib_pkg;

    localparam int CALIB_SIZE  = 18;
    localparam int SAMPLE_SIZE = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } calib_state_e;

endpackage

// File: rtl/calib_tracker_if.sv
// Sweep/sample inputs and lock result outputs of the calibration tracker.
interface calib_tracker_if
    import calib_pkg::*;
();

    logic                          i_calib_enabled;
    logic [CALIB_SIZE-1:0]         i_calib_value;
    logic                          i_sample_valid;
    logic signed [SAMPLE_SIZE-1:0] i_sample;
    logic                          o_sweeping;
    logic                          o_locked;
    logic [CALIB_SIZE-1:0]         o_locked_value;
    logic [SAMPLE_SIZE-2:0]        o_best_error;
    logic                          o_done;

    modport master (
        output i_calib_enabled, i_calib_value, i_sample_valid, i_sample,
        input  o_sweeping, o_locked, o_locked_value, o_best_error, o_done
    );

    modport slave (
        input  i_calib_enabled, i_calib_value, i_sample_valid, i_sample,
        output o_sweeping, o_locked, o_locked_value, o_best_error, o_done
    );

endinterface

// File: rtl/calib_step_acc.sv
// Per-step magnitude accumulator: sums the first 2**LW sample magnitudes of a step.
module calib_step_acc
    import calib_pkg::*;
#(
    parameter int LW = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          clear_i,
    input  logic                          load_i,
    input  logic                          accum_i,
    input  logic signed [SAMPLE_SIZE-1:0] sample_i,
    output logic                          count_full_o,
    output logic [SAMPLE_SIZE-2:0]        mean_o
);

    localparam int AW   = SAMPLE_SIZE - 1 + LW;
    localparam int CNTW = LW + 1;
    localparam logic [CNTW-1:0] WIN = CNTW'(1 << LW);

    logic [AW-1:0]          acc_q, acc_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic [SAMPLE_SIZE-1:0] neg;
    logic [SAMPLE_SIZE-2:0] mag;

    assign neg          = ~sample_i + 1'b1;
    assign count_full_o = (cnt_q == WIN);
    assign mean_o       = acc_q[AW-1:LW];

    // Absolute value; the most negative code saturates to the largest positive magnitude.
    always_comb begin
        mag = sample_i[SAMPLE_SIZE-2:0];
        if (sample_i[SAMPLE_SIZE-1]) begin
            if (sample_i[SAMPLE_SIZE-2:0] == '0) mag = '1;
            else                                 mag = neg[SAMPLE_SIZE-2:0];
        end
    end

    // Clear empties the window; load restarts it with the current sample (boundary cycle).
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (load_i) begin
            acc_d = accum_i ? AW'(mag) : '0;
            cnt_d = accum_i ? CNTW'(1) : '0;
        end else if (accum_i && !count_full_o) begin
            acc_d = acc_q + AW'(mag);
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Accumulator and sample count registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/calib_tracker.sv
// Tracks the calibration step whose mean sample magnitude is closest to TARGET
// and locks it when the sweep ends.
//
// state    | meaning
// ST_IDLE  | waiting for a rising edge of the sweep enable
// ST_SWEEP | measuring steps, tracking best error
// ST_DONE  | one cycle: publish lock result and pulse done
module calib_tracker
    import calib_pkg::*;
#(
    parameter int                     LOG2_WINDOW = 4,
    parameter logic [SAMPLE_SIZE-1:0] TARGET      = 16'd8192
) (
    input  logic            i_clock,
    input  logic            i_reset,
    calib_tracker_if.slave  bus
);

    localparam logic [SAMPLE_SIZE-2:0] TGT = TARGET[SAMPLE_SIZE-2:0];

    calib_state_e           state_q, state_d;
    logic                   en_q;
    logic [CALIB_SIZE-1:0]  step_q, step_d;
    logic                   bvalid_q, bvalid_d;
    logic [CALIB_SIZE-1:0]  bval_q, bval_d;
    logic [SAMPLE_SIZE-2:0] berr_q, berr_d;
    logic                   locked_q, locked_d;
    logic [CALIB_SIZE-1:0]  lval_q, lval_d;
    logic [SAMPLE_SIZE-2:0] lerr_q, lerr_d;
    logic                   done_q, done_d;

    logic                   rise, boundary, better, start;
    logic                   clear, load, accum, count_full;
    logic [SAMPLE_SIZE-2:0] mean, err;

    calib_step_acc #(.LW(LOG2_WINDOW)) u_acc (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .clear_i      (clear),
        .load_i       (load),
        .accum_i      (accum),
        .sample_i     (bus.i_sample),
        .count_full_o (count_full),
        .mean_o       (mean)
    );

    assign rise     = bus.i_calib_enabled & ~en_q;
    assign boundary = (bus.i_calib_value != step_q);
    assign err      = (mean >= TGT) ? (mean - TGT) : (TGT - mean);
    assign better   = count_full && (err < berr_q);

    assign bus.o_sweeping     = (state_q == ST_SWEEP);
    assign bus.o_locked       = locked_q;
    assign bus.o_locked_value = lval_q;
    assign bus.o_best_error   = lerr_q;
    assign bus.o_done         = done_q;

    // Next-state, step finalisation and lock publication.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        bvalid_d = bvalid_q;
        bval_d   = bval_q;
        berr_d   = berr_q;
        locked_d = locked_q;
        lval_d   = lval_q;
        lerr_d   = lerr_q;
        done_d   = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        accum    = 1'b0;
        start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start = rise;
            end
            ST_SWEEP: begin
                if (!bus.i_calib_enabled || boundary) begin
                    if (better) begin
                        bvalid_d = 1'b1;
                        bval_d   = step_q;
                        berr_d   = err;
                    end
                end
                if (!bus.i_calib_enabled) begin
                    state_d = ST_DONE;
                    clear   = 1'b1;
                end else if (boundary) begin
                    load   = 1'b1;
                    accum  = bus.i_sample_valid;
                    step_d = bus.i_calib_value;
                end else begin
                    accum = bus.i_sample_valid;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                start   = rise;
                if (bvalid_q) begin
                    locked_d = 1'b1;
                    lval_d   = bval_q;
                    lerr_d   = berr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d  = ST_SWEEP;
            clear    = 1'b1;
            bvalid_d = 1'b0;
            berr_d   = '1;
            step_d   = bus.i_calib_value;
        end
    end

    // State, edge-detect history, best tracking and output registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            step_q   <= '0;
            bvalid_q <= 1'b0;
            bval_q   <= '0;
            berr_q   <= '0;
            locked_q <= 1'b0;
            lval_q   <= '0;
            lerr_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= bus.i_calib_enabled;
            step_q   <= step_d;
            bvalid_q <= bvalid_d;
            bval_q   <= bval_d;
            berr_q   <= berr_d;
            locked_q <= locked_d;
            lval_q   <= lval_d;
            lerr_q   <= lerr_d;
            done_q   <= done_d;
        end
    end

endmodule
